// File: rtl/traffic_ctrl.sv
// traffic_ctrl: fixed-time four-phase intersection sequencer with all-red
// clearances and a flashing night mode. The time base is any change of the
// clock block's seconds-units digit (one tick per simulated second).
// Optional pedestrian request (early NS cut-off and walk lamp) is built when
// the macro TRAFFIC_PED_REQ_EN is defined.
module traffic_ctrl #(
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sec1,
  input  logic             daynight,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic [2:0]       ns_lt,
  output logic [2:0]       ew_lt,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase,
  output logic             night_mode
);

  typedef enum logic [2:0] {
    S_NS_G  = 3'd0,
    S_NS_Y  = 3'd1,
    S_AR1   = 3'd2,
    S_EW_G  = 3'd3,
    S_EW_Y  = 3'd4,
    S_AR2   = 3'd5,
    S_NIGHT = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] TG = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] TY = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] TA = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CUT = CNT_W'(3);
  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             blink_q, blink_d;
  logic [2:0]       ns_q, ns_d, ew_q, ew_d;
  logic             night_q, night_d;
  logic [3:0]       sec1_q;
  logic             tick;
  logic             expire;

`ifdef TRAFFIC_PED_REQ_EN
  logic ped_pend_q, ped_pend_d;
  logic walk_q, walk_d;
  logic ped_now;
`endif

  assign tick   = (sec1 != sec1_q);
  assign expire = tick && (remain_q <= ONE);

  // Next-state, countdown, blink and lamp decode (lamps follow the next state).
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    blink_d  = blink_q;
    if (tick && remain_q > ONE && state_q != S_NIGHT) remain_d = remain_q - ONE;
    case (state_q)
      S_NS_G: if (expire) begin state_d = S_NS_Y; remain_d = TY; end
      S_NS_Y: if (expire) begin state_d = S_AR1;  remain_d = TA; end
      S_EW_G: if (expire) begin state_d = S_EW_Y; remain_d = TY; end
      S_EW_Y: if (expire) begin state_d = S_AR2;  remain_d = TA; end
      S_AR1, S_AR2: begin
        // Day/night is only honoured at the end of a clearance phase.
        if (expire) begin
          if (!daynight) begin
            state_d  = S_NIGHT;
            remain_d = '0;
            blink_d  = 1'b1;
          end else if (state_q == S_AR1) begin
            state_d  = S_EW_G;
            remain_d = TG;
          end else begin
            state_d  = S_NS_G;
            remain_d = TG;
          end
        end
      end
      S_NIGHT: begin
        if (tick) begin
          blink_d = ~blink_q;
          if (daynight) begin
            state_d  = S_AR2;
            remain_d = TA;
          end
        end
      end
      default: begin
        state_d  = S_AR2;
        remain_d = TA;
        blink_d  = 1'b1;
      end
    endcase

`ifdef TRAFFIC_PED_REQ_EN
    // A pending request shortens the NS green to at most three seconds.
    ped_now    = ped_pend_q | ped_req;
    ped_pend_d = ped_now;
    if (ped_now && state_q == S_NS_G && state_d == S_NS_G && remain_d > CUT)
      remain_d = CUT;
    if (state_d == S_EW_G && state_q != S_EW_G) ped_pend_d = 1'b0;
    walk_d = (state_d == S_EW_G);
`endif

    ns_d = LT_R;
    ew_d = LT_R;
    case (state_d)
      S_NS_G:  ns_d = LT_G;
      S_NS_Y:  ns_d = LT_Y;
      S_EW_G:  ew_d = LT_G;
      S_EW_Y:  ew_d = LT_Y;
      S_NIGHT: begin
        ns_d = {1'b0, blink_d, 1'b0};
        ew_d = {blink_d, 2'b00};
      end
      default: ;
    endcase
    night_d = (state_d == S_NIGHT);
  end

  // Sequencer registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec1_q   <= 4'd0;
      state_q  <= S_AR2;
      remain_q <= TA;
      blink_q  <= 1'b1;
      ns_q     <= LT_R;
      ew_q     <= LT_R;
      night_q  <= 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
`endif
    end else begin
      sec1_q   <= sec1;
      state_q  <= state_d;
      remain_q <= remain_d;
      blink_q  <= blink_d;
      ns_q     <= ns_d;
      ew_q     <= ew_d;
      night_q  <= night_d;
`ifdef TRAFFIC_PED_REQ_EN
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
`endif
    end
  end

  assign ns_lt      = ns_q;
  assign ew_lt      = ew_q;
  assign remain     = remain_q;
  assign phase      = state_q;
  assign night_mode = night_q;
`ifdef TRAFFIC_PED_REQ_EN
  assign walk = walk_q;
`endif

endmodule

// File: doc/traffic_ctrl.md
Name: traffic_ctrl

Overview:
- Intersection light sequencer directly downstream of the time-of-day clock block.
- Consumes the clock's seconds-units digit (sec1) as its time base and the day/night flag (daynight).
- Drives red/yellow/green lamps for the north-south (NS) and east-west (EW) approaches, plus a remaining-seconds value for the LCD.
- Day: fixed-time four-phase cycle with all-red clearances. Night: flashing mode.

Parameters:
- T_GREEN, 10, green duration in simulated seconds (>=1).
- T_YELLOW, 3, yellow duration in simulated seconds (>=1).
- T_ALLRED, 1, all-red clearance duration in simulated seconds (>=1).
- CNT_W, 6, width of the phase countdown; every T_* must be < 2^CNT_W.

Ports:
- clk  input  1  system clock (same clock as the clock block).
- rst  input  1  synchronous active-high reset.
- sec1  input  4  BCD seconds-units digit from the clock block.
- daynight  input  1  1 = day, 0 = night.
- ns_lt  output  3  NS lamps {red, yellow, green}.
- ew_lt  output  3  EW lamps {red, yellow, green}.
- remain  output  CNT_W  seconds left in the current phase; 0 in night mode.
- phase  output  3  encoded state, for the display/debug.
- night_mode  output  1  high while in S_NIGHT.
- ped_req  input  1  pedestrian request pulse; present only with PED_REQ_EN.
- walk  output  1  pedestrian walk lamp; present only with PED_REQ_EN.

Behaviour:
Reset and tick
- Reset is synchronous and active-high, and dominates all other inputs. Only clk edges act as the clock.
- Tick generation: a sec1_q register captures sec1 every cycle; sec1_q resets to 0.
- tick = (sec1 != sec1_q), combinational. One tick equals one simulated second.
- The clock block's hour-advance button does not change sec1 and so produces no tick.
- Reset values: state S_AR2, remain = T_ALLRED, ns_lt = 3'b100, ew_lt = 3'b100, night_mode = 0, blink = 1, walk = 0.

States and lamp outputs (phase encoding in brackets)
- S_NS_G (0): ns 001, ew 100.
- S_NS_Y (1): ns 010, ew 100.
- S_AR1 (2): ns 100, ew 100.
- S_EW_G (3): ns 100, ew 001.
- S_EW_Y (4): ns 100, ew 010.
- S_AR2 (5): ns 100, ew 100.
- S_NIGHT (6): ns {0, blink, 0}, ew {blink, 0, 0}.

Countdown and transitions
- Outputs are registered and update on the cycle after the tick.
- In a timed state, a tick with remain > 1 decrements remain.
- A tick with remain == 1 moves to the next state and loads its duration, so every phase lasts exactly T ticks.
- Day sequence: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G.
- daynight is sampled only on the expiring tick of S_AR1 or S_AR2. If it is 0 there, the next state is S_NIGHT: remain = 0, blink = 1, night_mode = 1.
- Mid-phase daynight changes are ignored, so a green is never truncated.
- In S_NIGHT, each tick toggles blink.
- A tick with daynight == 1 in S_NIGHT exits to S_AR2 with remain = T_ALLRED. This gives an all-red before NS green.
- No tick: state, remain and blink hold.
- Multiple ticks in consecutive cycles (fast clock setting): each one is honoured.
- Illegal state encoding (7): recover to S_AR2 on the next cycle.

Optional Feature:
Macro TRAFFIC_PED_REQ_EN. When defined:
- Adds ped_req and walk, plus a ped_pend latch (reset 0).
- ped_pend sets on ped_req = 1.
- While in S_NS_G with ped_pend = 1 and remain > 3, remain is forced to 3 on the next cycle; this is the early cut-off.
- Entering S_EW_G clears ped_pend.
- walk = 1 throughout S_EW_G. If ped_req arrives during S_EW_G, it is latched for the next cycle.
- walk = 0 in S_NIGHT; ped_req is still latched in S_NIGHT.

When undefined: the ports are absent and timing is purely fixed.

Test Plan:
- Reset with daynight = 1, then step sec1 0 -> 1 -> 2... each cycle. Required: AR2 for 1 tick, then NS_G for 10 ticks (remain 10 down to 1), then NS_Y with ew_lt = 100 throughout.
- Full cycle at defaults. Required: period = 2 × (10 + 3 + 1) = 28 ticks; phase sequence 5, 0, 1, 2, 3, 4, 5, 0.
- Drop daynight to 0 mid EW_G. Required: EW_G and EW_Y complete; at AR2 expiry enter S_NIGHT; ns_lt alternates 010/000 and ew_lt alternates 100/000 per tick; remain = 0.
- Raise daynight to 1 in night. Required: next tick enters AR2 (both 100) for 1 tick, then NS_G with remain = 10.
- Hold sec1 constant for 100 cycles. Required: no state or remain change. Assert rst mid NS_Y. Required: next cycle shows AR2, remain = 1.
- With TRAFFIC_PED_REQ_EN: pulse ped_req at NS_G remain = 8. Required: remain becomes 3 next cycle, and walk = 1 for all 10 EW_G ticks.
